// File: rtl/kv_cache_pkg.sv
// Shared types for the key-value cache engine.
// Optional per-entry expiry is enabled by defining KV_CACHE_TTL_EN.
package kv_cache_pkg;

  typedef enum logic [1:0] {
    OP_GET   = 2'd0,
    OP_PUT   = 2'd1,
    OP_DEL   = 2'd2,
    OP_FLUSH = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_EXEC,
    S_RESP
  } state_e;

  typedef struct packed {
    logic succ;
    logic hit;
    logic evict;
  } kv_rsp_t;

endpackage

// File: rtl/kv_cache_if.sv
// Request/response bundle of the key-value cache engine.
// req_ttl is present only when KV_CACHE_TTL_EN is defined.
interface kv_cache_if
  import kv_cache_pkg::*;
#(
  parameter int KW = 16,
  parameter int VW = 64,
  parameter int TW = 8,
  parameter int CW = 5
) ();
  logic          req_valid;
  logic          req_ready;
  op_e           req_op;
  logic [KW-1:0] req_key;
  logic [VW-1:0] req_value;
`ifdef KV_CACHE_TTL_EN
  logic [TW-1:0] req_ttl;
`endif
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_succ;
  logic          rsp_hit;
  logic          rsp_evict;
  logic [VW-1:0] rsp_value;
  logic [CW-1:0] used_count;

  modport master (
`ifdef KV_CACHE_TTL_EN
    output req_ttl,
`endif
    output req_valid, req_op, req_key,
    output req_value, rsp_ready,
    input  req_ready, rsp_valid, rsp_succ,
    input  rsp_hit, rsp_evict, rsp_value,
    input  used_count
  );

  modport slave (
`ifdef KV_CACHE_TTL_EN
    input  req_ttl,
`endif
    input  req_valid, req_op, req_key,
    input  req_value, rsp_ready,
    output req_ready, rsp_valid, rsp_succ,
    output rsp_hit, rsp_evict, rsp_value,
    output used_count
  );
endinterface

// File: rtl/kv_lru_tracker.sv
// LRU age array; ages of used entries form a permutation 0..used-1.
// victim_o flags the used entry holding the oldest age.
module kv_lru_tracker #(
  parameter  int N  = 16,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          touch_i,
  input  logic          insert_i,
  input  logic          remove_i,
  input  logic          flush_i,
  input  logic [AW-1:0] idx_i,
  input  logic [N-1:0]  used_i,
  output logic [N-1:0]  victim_o
);
  logic [AW-1:0] age_q [N];
  logic [AW-1:0] age_d [N];
  logic [AW-1:0] ref_a;

  assign ref_a = age_q[idx_i];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      age_d[i] = age_q[i];
      victim_o[i] = used_i[i] &&
                    (age_q[i] == AW'(N - 1));
    end
    for (int i = 0; i < N; i++) begin
      unique case (1'b1)
        flush_i: age_d[i] = '0;
        touch_i: begin
          if (AW'(i) == idx_i)
            age_d[i] = '0;
          else if (used_i[i] && age_q[i] < ref_a)
            age_d[i] = age_q[i] + 1'b1;
        end
        insert_i: begin
          if (AW'(i) == idx_i)
            age_d[i] = '0;
          else if (used_i[i])
            age_d[i] = age_q[i] + 1'b1;
        end
        remove_i: begin
          if (AW'(i) == idx_i)
            age_d[i] = '0;
          else if (used_i[i] && age_q[i] > ref_a)
            age_d[i] = age_q[i] - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        age_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        age_q[i] <= age_d[i];
    end
  end
endmodule

// File: rtl/kv_cache_core.sv
// Key-value cache engine: GET/PUT/DEL/FLUSH with LRU eviction.
// Define KV_CACHE_TTL_EN for per-entry expiry.
module kv_cache_core
  import kv_cache_pkg::*;
#(
  parameter int NUM_ENTRIES  = 16,
  parameter int KEY_WIDTH    = 16,
  parameter int VALUE_WIDTH  = 64,
  parameter int TTL_WIDTH    = 8,
  parameter int TTL_PRESCALE = 1024
) (
  input logic       clk,
  input logic       rst_n,
  kv_cache_if.slave bus
);
  localparam int N  = NUM_ENTRIES;
  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;

  state_e                 state_q;
  op_e                    op_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] val_q;
  logic                   hit_q, full_q;
  logic [AW-1:0]          hidx_q, fidx_q;
  logic [KEY_WIDTH-1:0]   keys_q [N];
  logic [VALUE_WIDTH-1:0] vals_q [N];
  logic [N-1:0]           used_q;
  kv_rsp_t                rsp_q, rsp_d;
  logic                   rsp_valid_q;
  logic [VALUE_WIDTH-1:0] rval_q, rval_d;

  logic          hit_c, full_c;
  logic [AW-1:0] hidx_c, fidx_c, vidx, wr_idx;
  logic [N-1:0]  victim;
  logic          wr_en, clr_en, flush_en;
  logic          touch_en, ins_en;
  logic          kill_en;
  logic [AW-1:0] kill_idx;
  logic [CW-1:0] cnt;

  // Descending scan: the lowest matching index wins.
  always_comb begin
    hit_c  = 1'b0;
    full_c = 1'b1;
    hidx_c = '0;
    fidx_c = '0;
    vidx   = '0;
    cnt    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (used_q[i] && keys_q[i] == key_q) begin
        hit_c  = 1'b1;
        hidx_c = AW'(i);
      end
      if (!used_q[i]) begin
        full_c = 1'b0;
        fidx_c = AW'(i);
      end
      if (victim[i]) vidx = AW'(i);
      cnt = cnt + CW'(used_q[i]);
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    clr_en   = 1'b0;
    flush_en = 1'b0;
    touch_en = 1'b0;
    ins_en   = 1'b0;
    rsp_d    = '0;
    rval_d   = '0;
    wr_idx   = hit_q ? hidx_q :
               (full_q ? vidx : fidx_q);
    if (state_q == S_EXEC) begin
      unique case (1'b1)
        (op_q == OP_GET): begin
          rsp_d.succ = hit_q;
          rsp_d.hit  = hit_q;
          touch_en   = hit_q;
          if (hit_q) rval_d = vals_q[hidx_q];
        end
        (op_q == OP_PUT): begin
          wr_en       = 1'b1;
          rsp_d.succ  = 1'b1;
          rsp_d.hit   = hit_q;
          rsp_d.evict = !hit_q && full_q;
          touch_en    = hit_q;
          ins_en      = !hit_q;
        end
        (op_q == OP_DEL): begin
          clr_en     = hit_q;
          rsp_d.succ = hit_q;
          rsp_d.hit  = hit_q;
        end
        (op_q == OP_FLUSH): begin
          flush_en   = 1'b1;
          rsp_d.succ = 1'b1;
        end
        default: ;
      endcase
    end
  end

  kv_lru_tracker #(.N(N)) u_lru (
    .clk      (clk),
    .rst_n    (rst_n),
    .touch_i  (touch_en),
    .insert_i (ins_en),
    .remove_i (clr_en | kill_en),
    .flush_i  (flush_en),
    .idx_i    (kill_en ? kill_idx : wr_idx),
    .used_i   (used_q),
    .victim_o (victim)
  );

`ifdef KV_CACHE_TTL_EN
  localparam int PW = $clog2(TTL_PRESCALE + 1);

  logic [TTL_WIDTH-1:0] ttl_q;
  logic [TTL_WIDTH-1:0] life_q [N];
  logic [N-1:0]         exp_q;
  logic [PW-1:0]        pre_q;
  logic                 tick;

  assign tick = (state_q == S_IDLE) &&
                (pre_q == PW'(TTL_PRESCALE - 1));

  always_comb begin
    kill_en  = 1'b0;
    kill_idx = '0;
    if (state_q == S_IDLE) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (exp_q[i] && used_q[i]) begin
          kill_en  = 1'b1;
          kill_idx = AW'(i);
        end
      end
    end
  end

  // Expired entries park at lifetime 0 until their turn to be removed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ttl_q <= '0;
      exp_q <= '0;
      pre_q <= '0;
      for (int i = 0; i < N; i++)
        life_q[i] <= '0;
    end else begin
      if (state_q == S_IDLE && bus.req_valid)
        ttl_q <= bus.req_ttl;
      if (state_q == S_IDLE)
        pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) begin
        for (int i = 0; i < N; i++) begin
          if (used_q[i] && life_q[i] != '0) begin
            life_q[i] <= life_q[i] - 1'b1;
            if (life_q[i] == TTL_WIDTH'(1))
              exp_q[i] <= 1'b1;
          end
        end
      end
      if (kill_en) exp_q[kill_idx] <= 1'b0;
      if (clr_en) exp_q[hidx_q] <= 1'b0;
      if (wr_en) begin
        life_q[wr_idx] <= ttl_q;
        exp_q[wr_idx]  <= 1'b0;
      end
      if (flush_en) begin
        exp_q <= '0;
        for (int i = 0; i < N; i++)
          life_q[i] <= '0;
      end
    end
  end
`else
  assign kill_en  = 1'b0;
  assign kill_idx = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_GET;
      key_q       <= '0;
      val_q       <= '0;
      hit_q       <= 1'b0;
      full_q      <= 1'b0;
      hidx_q      <= '0;
      fidx_q      <= '0;
      used_q      <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rval_q      <= '0;
      for (int i = 0; i < N; i++) begin
        keys_q[i] <= '0;
        vals_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.req_valid) begin
          op_q    <= bus.req_op;
          key_q   <= bus.req_key;
          val_q   <= bus.req_value;
          state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          hit_q   <= hit_c;
          full_q  <= full_c;
          hidx_q  <= hidx_c;
          fidx_q  <= fidx_c;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          rsp_q       <= rsp_d;
          rval_q      <= rval_d;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: if (bus.rsp_ready) begin
          rsp_q       <= '0;
          rval_q      <= '0;
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (wr_en) begin
        keys_q[wr_idx] <= key_q;
        vals_q[wr_idx] <= val_q;
        used_q[wr_idx] <= 1'b1;
      end
      if (clr_en) used_q[hidx_q] <= 1'b0;
      if (kill_en) used_q[kill_idx] <= 1'b0;
      if (flush_en) used_q <= '0;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_succ   = rsp_q.succ;
  assign bus.rsp_hit    = rsp_q.hit;
  assign bus.rsp_evict  = rsp_q.evict;
  assign bus.rsp_value  = rval_q;
  assign bus.used_count = cnt;
endmodule

// File: tb/tb_kv_cache_core.sv
// Directed bench for kv_cache_core.
// Define KV_CACHE_TTL_EN to also exercise expiry.
module tb_kv_cache_core;
  import kv_cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  logic        r_succ, r_hit, r_evict;
  logic [63:0] r_val;
  logic [4:0]  r_cnt;
  int          lat;
  logic        stable;
  logic        seen;
`ifdef KV_CACHE_TTL_EN
  logic [7:0]  ttl_v = '0;
`endif

  always #5 clk = ~clk;

  kv_cache_if #(
    .KW(16), .VW(64), .TW(8), .CW(5)
  ) bus ();

  kv_cache_core #(
    .NUM_ENTRIES  (16),
    .KEY_WIDTH    (16),
    .VALUE_WIDTH  (64),
    .TTL_WIDTH    (8),
    .TTL_PRESCALE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic xact(input op_e op,
                      input logic [15:0] k,
                      input logic [63:0] v,
                      input int hold);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = k;
    bus.req_value = v;
`ifdef KV_CACHE_TTL_EN
    bus.req_ttl   = ttl_v;
`endif
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!bus.rsp_valid) chk("rsp_timeout", 0, 1);
    r_succ  = bus.rsp_succ;
    r_hit   = bus.rsp_hit;
    r_evict = bus.rsp_evict;
    r_val   = bus.rsp_value;
    r_cnt   = bus.used_count;
    stable  = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b1 ||
          bus.rsp_succ !== r_succ ||
          bus.rsp_value !== r_val ||
          bus.req_ready !== 1'b0)
        stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = OP_GET;
    bus.req_key   = '0;
    bus.req_value = '0;
`ifdef KV_CACHE_TTL_EN
    bus.req_ttl   = '0;
`endif
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_used", bus.used_count, 0);
    chk("rst_value", bus.rsp_value, 0);
    chk("rst_flags", {bus.rsp_succ, bus.rsp_hit,
                      bus.rsp_evict}, 0);
    @(negedge clk) rst_n = 1'b1;

    xact(OP_GET, 16'h1, 0, 0);
    chk("get0_lat", lat, 3);
    chk("get0_succ", r_succ, 0);
    chk("get0_hit", r_hit, 0);
    chk("get0_val", r_val, 0);
    chk("get0_cnt", r_cnt, 0);

    xact(OP_PUT, 16'h1, 64'hDEAD_BEEF, 0);
    chk("put1_succ", r_succ, 1);
    chk("put1_hit", r_hit, 0);
    chk("put1_cnt", r_cnt, 1);
    xact(OP_GET, 16'h1, 0, 0);
    chk("get1_succ", r_succ, 1);
    chk("get1_hit", r_hit, 1);
    chk("get1_val", r_val, 64'hDEAD_BEEF);
    xact(OP_PUT, 16'h1, 64'h1, 0);
    chk("put1b_hit", r_hit, 1);
    chk("put1b_cnt", r_cnt, 1);
    xact(OP_GET, 16'h1, 0, 0);
    chk("get1b_val", r_val, 64'h1);

    xact(OP_FLUSH, 0, 0, 0);
    chk("flush0_cnt", r_cnt, 0);
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      xact(OP_PUT, 16'(k), 64'h100 + 64'(k), 0);
      if (r_evict || !r_succ) seen = 1'b1;
    end
    chk("fill_noevict", seen, 0);
    chk("fill_cnt", r_cnt, 16);
    xact(OP_GET, 16'h0, 0, 0);
    chk("touch0_val", r_val, 64'h100);
    xact(OP_PUT, 16'h10, 64'h116, 0);
    chk("evict_flag", r_evict, 1);
    chk("evict_succ", r_succ, 1);
    chk("evict_cnt", r_cnt, 16);
    xact(OP_GET, 16'h1, 0, 0);
    chk("lru_gone_hit", r_hit, 0);
    chk("lru_gone_val", r_val, 0);
    xact(OP_GET, 16'h0, 0, 0);
    chk("mru_kept_hit", r_hit, 1);
    xact(OP_GET, 16'h10, 0, 0);
    chk("new_val", r_val, 64'h116);

    xact(OP_DEL, 16'h5, 0, 0);
    chk("del_succ", r_succ, 1);
    chk("del_cnt", r_cnt, 15);
    xact(OP_DEL, 16'h5, 0, 0);
    chk("del2_succ", r_succ, 0);
    chk("del2_cnt", r_cnt, 15);
    xact(OP_PUT, 16'h20, 64'h220, 0);
    chk("refill_evict", r_evict, 0);
    chk("refill_cnt", r_cnt, 16);
    xact(OP_FLUSH, 0, 0, 0);
    chk("flush_succ", r_succ, 1);
    chk("flush_hit", r_hit, 0);
    chk("flush_cnt", r_cnt, 0);
    xact(OP_GET, 16'h0, 0, 0);
    chk("post_flush_hit", r_hit, 0);

    xact(OP_PUT, 16'h7, 64'h77, 10);
    chk("hold_stable", stable, 1);
    chk("hold_succ", r_succ, 1);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_GET;
    bus.req_key   = 16'h7;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.rsp_valid, 0);
    chk("midrst_ready", bus.req_ready, 1);
    chk("midrst_cnt", bus.used_count, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1 if (bus.rsp_valid) seen = 1'b1;
    end
    chk("midrst_norsp", seen, 0);
    xact(OP_GET, 16'h7, 0, 0);
    chk("midrst_cleared", r_hit, 0);

`ifdef KV_CACHE_TTL_EN
    ttl_v = 8'd0;
    xact(OP_PUT, 16'h31, 64'h31, 0);
    ttl_v = 8'd2;
    xact(OP_PUT, 16'h30, 64'h30, 0);
    repeat (8) @(posedge clk);
    ttl_v = 8'd0;
    xact(OP_GET, 16'h30, 0, 0);
    chk("ttl_expired", r_hit, 0);
    repeat (100) @(posedge clk);
    xact(OP_GET, 16'h31, 0, 0);
    chk("ttl0_kept", r_hit, 1);
    chk("ttl0_val", r_val, 64'h31);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule
